sim_dram_rd_arbiter: RTL and testbench

//   Shares the simulation DRAM model's AXI read channels (AR/R) among NM requesters.

---
 rtl/sim_dram_rd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sim_dram_rd_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_dram_rd_arbiter.sv
// Shares the DRAM model's AXI AR/R channels among NM requesters: round-robin AR
// arbitration into a registered slot, requester-index ID tagging and tag-routed R beats.
module sim_dram_rd_arbiter #(
  parameter int NM        = 2,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 4,
  parameter int MAX_OUT   = 8,
  localparam int IW  = (NM > 1) ? $clog2(NM) : 1,
  localparam int SID = ID_BITS + IW
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NM-1:0]           m_ar_valid,
  output logic [NM-1:0]           m_ar_ready,
  input  logic [NM*ADDR_BITS-1:0] m_ar_addr,
  input  logic [NM*8-1:0]         m_ar_len,
  input  logic [NM*3-1:0]         m_ar_size,
  input  logic [NM*ID_BITS-1:0]   m_ar_id,
  output logic [NM-1:0]           m_r_valid,
  input  logic [NM-1:0]           m_r_ready,
  output logic [DATA_BITS-1:0]    m_r_data,
  output logic [1:0]              m_r_resp,
  output logic                    m_r_last,
  output logic [ID_BITS-1:0]      m_r_id,
  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  output logic [ADDR_BITS-1:0]    s_ar_addr,
  output logic [7:0]              s_ar_len,
  output logic [2:0]              s_ar_size,
  output logic [SID-1:0]          s_ar_id,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  input  logic [DATA_BITS-1:0]    s_r_data,
  input  logic [1:0]              s_r_resp,
  input  logic                    s_r_last,
  input  logic [SID-1:0]          s_r_id
);

  logic                 ar_valid_r;
  logic [ADDR_BITS-1:0] ar_addr_r;
  logic [7:0]           ar_len_r;
  logic [2:0]           ar_size_r;
  logic [SID-1:0]       ar_id_r;
  logic [IW-1:0]        rr_r;
  logic [7:0]           cnt_r [NM];

  logic                 free_s;
  logic [NM-1:0]        eligible_s;
  logic [2*NM-1:0]      elig2_s;
  logic                 found_s;
  logic [IW:0]          offset_s;
  logic [IW:0]          sum_s;
  logic [IW-1:0]        grant_idx_s;
  logic [IW-1:0]        rr_next_s;
  logic [NM-1:0]        grant_s;
  logic [ADDR_BITS-1:0] sel_addr_s;
  logic [7:0]           sel_len_s;
  logic [2:0]           sel_size_s;
  logic [ID_BITS-1:0]   sel_id_s;

  logic [IW-1:0]        tag_s;
  logic                 tag_ok_s;
  logic                 ready_sel_s;
  logic [NM-1:0]        r_valid_s;
  logic                 s_r_ready_s;
  logic [NM-1:0]        dec_s;

  // Round-robin pick: rotate the eligible mask so rr sits at bit 0, take the lowest set bit
  always_comb begin
    free_s = !ar_valid_r || s_ar_ready;
    for (int i = 0; i < NM; i++) begin
      eligible_s[i] = m_ar_valid[i] && (cnt_r[i] < 8'(MAX_OUT));
    end
    elig2_s  = {eligible_s, eligible_s} >> rr_r;
    found_s  = 1'b0;
    offset_s = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      offset_s = elig2_s[k] ? (IW+1)'(k) : offset_s;
      found_s  = found_s | elig2_s[k];
    end
    sum_s       = {1'b0, rr_r} + offset_s;
    grant_idx_s = (sum_s >= (IW+1)'(NM)) ? IW'(sum_s - (IW+1)'(NM)) : IW'(sum_s);
    rr_next_s   = (grant_idx_s == IW'(NM - 1)) ? '0 : grant_idx_s + IW'(1);
    for (int i = 0; i < NM; i++) begin
      grant_s[i] = found_s && free_s && !reset && (grant_idx_s == IW'(i));
    end
  end

  // Field mux for the granted requester (grant is one-hot, so OR-combine)
  always_comb begin
    sel_addr_s = '0;
    sel_len_s  = '0;
    sel_size_s = '0;
    sel_id_s   = '0;
    for (int i = 0; i < NM; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_BITS{grant_s[i]}} & m_ar_addr[i*ADDR_BITS +: ADDR_BITS]);
      sel_len_s  = sel_len_s  | ({8{grant_s[i]}} & m_ar_len[i*8 +: 8]);
      sel_size_s = sel_size_s | ({3{grant_s[i]}} & m_ar_size[i*3 +: 3]);
      sel_id_s   = sel_id_s   | ({ID_BITS{grant_s[i]}} & m_ar_id[i*ID_BITS +: ID_BITS]);
    end
  end

  // R demux by tag; an out-of-range tag is swallowed so the DRAM model never stalls on it
  always_comb begin
    tag_s       = s_r_id[SID-1:ID_BITS];
    tag_ok_s    = 1'b0;
    ready_sel_s = 1'b0;
    for (int i = 0; i < NM; i++) begin
      r_valid_s[i] = s_r_valid && (tag_s == IW'(i));
      tag_ok_s     = tag_ok_s | (tag_s == IW'(i));
      ready_sel_s  = ready_sel_s | ((tag_s == IW'(i)) && m_r_ready[i]);
    end
    s_r_ready_s = tag_ok_s ? ready_sel_s : 1'b1;
    for (int i = 0; i < NM; i++) begin
      dec_s[i] = r_valid_s[i] && s_r_ready_s && s_r_last;
    end
  end

  // AR slot register and round-robin pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar_valid_r <= 1'b0;
      ar_addr_r  <= '0;
      ar_len_r   <= 8'd0;
      ar_size_r  <= 3'd0;
      ar_id_r    <= '0;
      rr_r       <= '0;
    end else if (free_s) begin
      if (found_s) begin
        ar_valid_r <= 1'b1;
        ar_addr_r  <= sel_addr_s;
        ar_len_r   <= sel_len_s;
        ar_size_r  <= sel_size_s;
        ar_id_r    <= {grant_idx_s, sel_id_s};
        rr_r       <= rr_next_s;
      end else begin
        ar_valid_r <= 1'b0;
      end
    end
  end

  // Outstanding-burst counters; grant is already gated by cnt < MAX_OUT
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NM; i++) cnt_r[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NM; i++) begin
        if (grant_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + 8'd1;
        end else if (dec_s[i] && !grant_s[i] && (cnt_r[i] != 8'd0)) begin
          cnt_r[i] <= cnt_r[i] - 8'd1;
        end
      end
    end
  end

  assign m_ar_ready = grant_s;
  assign s_ar_valid = ar_valid_r;
  assign s_ar_addr  = ar_addr_r;
  assign s_ar_len   = ar_len_r;
  assign s_ar_size  = ar_size_r;
  assign s_ar_id    = ar_id_r;
  assign m_r_valid  = r_valid_s;
  assign s_r_ready  = s_r_ready_s;
  assign m_r_data   = s_r_data;
  assign m_r_resp   = s_r_resp;
  assign m_r_last   = s_r_last;
  assign m_r_id     = s_r_id[ID_BITS-1:0];

endmodule

// File: tb/tb_sim_dram_rd_arbiter.sv
// Bench for sim_dram_rd_arbiter (NM=3, MAX_OUT=2): directed scenarios with literal
// expectations, then random traffic checked every cycle against a behavioural model.
module tb_sim_dram_rd_arbiter;
  localparam int NM  = 3;
  localparam int AB  = 32;
  localparam int DB  = 64;
  localparam int IB  = 4;
  localparam int MO  = 2;
  localparam int SID = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NM-1:0]    m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [NM*AB-1:0] m_ar_addr;
  logic [NM*8-1:0]  m_ar_len;
  logic [NM*3-1:0]  m_ar_size;
  logic [NM*IB-1:0] m_ar_id;
  logic [DB-1:0]    m_r_data, s_r_data;
  logic [1:0]       m_r_resp, s_r_resp;
  logic             m_r_last, s_r_last;
  logic [IB-1:0]    m_r_id;
  logic             s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [AB-1:0]    s_ar_addr;
  logic [7:0]       s_ar_len;
  logic [2:0]       s_ar_size;
  logic [SID-1:0]   s_ar_id, s_r_id;

  logic [AB-1:0] ar_addr_a [NM];
  logic [7:0]    ar_len_a  [NM];
  logic [2:0]    ar_size_a [NM];
  logic [IB-1:0] ar_id_a   [NM];
  assign m_ar_addr = {ar_addr_a[2], ar_addr_a[1], ar_addr_a[0]};
  assign m_ar_len  = {ar_len_a[2], ar_len_a[1], ar_len_a[0]};
  assign m_ar_size = {ar_size_a[2], ar_size_a[1], ar_size_a[0]};
  assign m_ar_id   = {ar_id_a[2], ar_id_a[1], ar_id_a[0]};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sim_dram_rd_arbiter #(.NM(NM), .ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB), .MAX_OUT(MO)) dut (
    .clock(clock), .reset(reset),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_id(s_r_id)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  // Behavioural model: outstanding counts, rotation pointer and the single AR slot
  int         cnt_m [NM];
  logic [1:0] rr_m;
  logic       sv_m;
  logic [AB-1:0]  sa_m;
  logic [7:0]     sl_m;
  logic [2:0]     ss_m;
  logic [SID-1:0] si_m;
  logic [1:0] gi, tg_m;
  logic       g_ok, fr_m, tag_ok_m, dt_ok;
  logic [2:0] e_rdy, e_rv;
  logic       e_srr;
  int         t_m;

  always @(negedge clock) begin
    tg_m     = s_r_id[5:4];
    tag_ok_m = (tg_m != 2'd3);
    e_rv     = tag_ok_m ? (3'(s_r_valid) << tg_m) : 3'b000;
    e_srr    = tag_ok_m ? m_r_ready[tg_m] : 1'b1;
    g_ok = 1'b0;
    gi   = 2'd0;
    fr_m = 1'b0;
    if (reset) begin
      for (int i = 0; i < NM; i++) cnt_m[i] = 0;
      rr_m = 2'd0; sv_m = 1'b0; sa_m = '0; sl_m = '0; ss_m = '0; si_m = '0;
      e_rdy = 3'b000;
    end else begin
      fr_m = !sv_m || s_ar_ready;
      for (int k = 0; k < NM; k++) begin
        t_m = int'(rr_m) + k;
        if (t_m >= NM) t_m = t_m - NM;
        if (!g_ok && m_ar_valid[2'(t_m)] && cnt_m[2'(t_m)] < MO) begin
          g_ok = 1'b1;
          gi   = 2'(t_m);
        end
      end
      e_rdy = (fr_m && g_ok) ? (3'b001 << gi) : 3'b000;
    end
    chk("m_ar_ready", 64'(m_ar_ready), 64'(e_rdy));
    chk("s_ar_valid", 64'(s_ar_valid), 64'(sv_m));
    if (sv_m || reset) begin
      chk("s_ar_addr", 64'(s_ar_addr), 64'(sa_m));
      chk("s_ar_len", 64'(s_ar_len), 64'(sl_m));
      chk("s_ar_size", 64'(s_ar_size), 64'(ss_m));
      chk("s_ar_id", 64'(s_ar_id), 64'(si_m));
    end
    chk("m_r_valid", 64'(m_r_valid), 64'(e_rv));
    chk("s_r_ready", 64'(s_r_ready), 64'(e_srr));
    chk("m_r_data", m_r_data, s_r_data);
    chk("m_r_resp_last", 64'({m_r_resp, m_r_last}), 64'({s_r_resp, s_r_last}));
    chk("m_r_id", 64'(m_r_id), 64'(s_r_id[3:0]));
    if (!reset) begin
      dt_ok = s_r_valid && e_srr && s_r_last && tag_ok_m;
      for (int i = 0; i < NM; i++) begin
        if (e_rdy[i] && !(dt_ok && tg_m == 2'(i))) cnt_m[i] = cnt_m[i] + 1;
        else if (!e_rdy[i] && dt_ok && tg_m == 2'(i) && cnt_m[i] > 0) cnt_m[i] = cnt_m[i] - 1;
      end
      if (fr_m) begin
        if (g_ok) begin
          sv_m = 1'b1;
          sa_m = ar_addr_a[gi];
          sl_m = ar_len_a[gi];
          ss_m = ar_size_a[gi];
          si_m = {gi, ar_id_a[gi]};
          rr_m = (gi == 2'd2) ? 2'd0 : gi + 2'd1;
        end else begin
          sv_m = 1'b0;
        end
      end
    end
  end

  task automatic drain(input logic [1:0] tag, input int n);
    for (int j = 0; j < n; j++) begin
      s_r_valid = 1'b1; s_r_last = 1'b1; s_r_id = {tag, 4'h0};
      tick();
    end
    s_r_valid = 1'b0; s_r_last = 1'b0;
  endtask

  logic [1:0] seq [6];

  initial begin
    m_ar_valid = '0; s_ar_ready = 1'b0; s_r_valid = 1'b0; m_r_ready = '0;
    s_r_data = '0; s_r_resp = 2'd0; s_r_last = 1'b0; s_r_id = '0;
    for (int i = 0; i < NM; i++) begin
      ar_addr_a[i] = '0; ar_len_a[i] = '0; ar_size_a[i] = '0; ar_id_a[i] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;
    at_neg();
    chk("rst_s_ar_valid", 64'(s_ar_valid), 64'd0);
    chk("rst_m_ar_ready", 64'(m_ar_ready), 64'd0);
    tick();

    // single request from requester 0
    ar_addr_a[0] = 32'h0000_1000; ar_len_a[0] = 8'd3; ar_size_a[0] = 3'd3; ar_id_a[0] = 4'h5;
    m_ar_valid = 3'b001; s_ar_ready = 1'b1; m_r_ready = 3'b111;
    at_neg();
    chk("single_grant", 64'(m_ar_ready), 64'(3'b001));
    tick();
    m_ar_valid = 3'b000;
    at_neg();
    chk("single_s_ar_valid", 64'(s_ar_valid), 64'd1);
    chk("single_s_ar_id", 64'(s_ar_id), 64'h05);
    chk("single_s_ar_addr", 64'(s_ar_addr), 64'h1000);
    chk("single_s_ar_len", 64'(s_ar_len), 64'd3);
    tick();
    for (int b = 0; b < 4; b++) begin
      s_r_valid = 1'b1; s_r_id = 6'h05; s_r_last = (b == 3); s_r_data = {$urandom, $urandom};
      at_neg();
      chk("single_r_valid", 64'(m_r_valid), 64'(3'b001));
      chk("single_r_id", 64'(m_r_id), 64'h5);
      tick();
    end
    s_r_valid = 1'b0; s_r_last = 1'b0;

    // contention: everyone valid, rotation starts at 1, each stops at MAX_OUT
    seq = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < NM; i++) begin
      ar_id_a[i] = 4'(i + 8); ar_addr_a[i] = 32'(i * 256);
    end
    m_ar_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      at_neg();
      chk("rr_grant", 64'(m_ar_ready), 64'(3'b001 << seq[j]));
      if (j > 0) chk("rr_tag", 64'(s_ar_id[5:4]), 64'(seq[j-1]));
      tick();
    end
    at_neg();
    chk("rr_all_at_limit", 64'(m_ar_ready), 64'd0);
    chk("rr_last_tag", 64'(s_ar_id), 64'h08);
    tick();
    m_ar_valid = 3'b000;
    drain(2'd0, 2); drain(2'd1, 2); drain(2'd2, 2);

    // AR backpressure: slot holds while the requester's fields change underneath
    s_ar_ready = 1'b0; m_ar_valid = 3'b100; ar_addr_a[2] = 32'hCAFE_0000;
    at_neg();
    chk("bp_first_grant", 64'(m_ar_ready), 64'(3'b100));
    tick();
    ar_addr_a[2] = 32'hDEAD_0000;
    repeat (5) begin
      at_neg();
      chk("bp_no_grant", 64'(m_ar_ready), 64'd0);
      chk("bp_addr_hold", 64'(s_ar_addr), 64'hCAFE_0000);
      tick();
    end
    s_ar_ready = 1'b1;
    at_neg();
    chk("bp_regrant", 64'(m_ar_ready), 64'(3'b100));
    tick();
    m_ar_valid = 3'b000;
    at_neg();
    chk("bp_new_addr", 64'(s_ar_addr), 64'hDEAD_0000);
    tick();
    drain(2'd2, 2);

    // outstanding limit on requester 1
    m_ar_valid = 3'b010;
    at_neg(); chk("limit_g1", 64'(m_ar_ready), 64'(3'b010)); tick();
    at_neg(); chk("limit_g2", 64'(m_ar_ready), 64'(3'b010)); tick();
    at_neg(); chk("limit_block", 64'(m_ar_ready), 64'd0); tick();
    s_r_valid = 1'b1; s_r_last = 1'b1; s_r_id = 6'h13;
    at_neg(); chk("limit_block_same_cycle", 64'(m_ar_ready), 64'd0); tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    at_neg(); chk("limit_release", 64'(m_ar_ready), 64'(3'b010)); tick();
    m_ar_valid = 3'b000;

    // R backpressure and an out-of-range tag
    s_r_valid = 1'b1; s_r_last = 1'b1; s_r_id = 6'h13; m_r_ready = 3'b101;
    at_neg();
    chk("rbp_ready", 64'(s_r_ready), 64'd0);
    chk("rbp_valid", 64'(m_r_valid), 64'(3'b010));
    tick();
    s_r_id = 6'h37; m_r_ready = 3'b000;
    at_neg();
    chk("badtag_valid", 64'(m_r_valid), 64'd0);
    chk("badtag_ready", 64'(s_r_ready), 64'd1);
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0; m_r_ready = 3'b111; m_ar_valid = 3'b010;
    at_neg(); chk("badtag_cnt_held", 64'(m_ar_ready), 64'd0); tick();
    m_ar_valid = 3'b000;
    drain(2'd1, 2);

    // async reset with a pending AR and requester 0 at its limit
    m_ar_valid = 3'b001;
    at_neg(); chk("pre_rst_g1", 64'(m_ar_ready), 64'(3'b001)); tick();
    at_neg(); chk("pre_rst_g2", 64'(m_ar_ready), 64'(3'b001)); tick();
    s_ar_ready = 1'b0;
    at_neg();
    chk("pre_rst_valid", 64'(s_ar_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(s_ar_valid), 64'd0);
    chk("async_rst_addr", 64'(s_ar_addr), 64'd0);
    chk("async_rst_ready", 64'(m_ar_ready), 64'd0);
    s_r_valid = 1'b1; s_r_last = 1'b1; s_r_id = 6'h00;
    #1;
    chk("rst_late_r", 64'(m_r_valid), 64'(3'b001));
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    tick();
    reset = 1'b0; s_ar_ready = 1'b1;
    at_neg(); chk("post_rst_g1", 64'(m_ar_ready), 64'(3'b001)); tick();
    at_neg(); chk("post_rst_g2", 64'(m_ar_ready), 64'(3'b001)); tick();
    m_ar_valid = 3'b000;
    drain(2'd0, 2);

    // random traffic, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      m_ar_valid = 3'($urandom);
      s_ar_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NM; i++) begin
        ar_addr_a[i] = $urandom; ar_len_a[i] = 8'($urandom);
        ar_size_a[i] = 3'($urandom); ar_id_a[i] = 4'($urandom);
      end
      s_r_valid = 1'($urandom_range(0, 1));
      s_r_last  = 1'($urandom_range(0, 1));
      s_r_id    = {2'($urandom_range(0, 3)), 4'($urandom)};
      s_r_data  = {$urandom, $urandom};
      s_r_resp  = 2'($urandom);
      m_r_ready = 3'($urandom);
      if (c == 1500) reset = 1'b1;
      if (c == 1503) reset = 1'b0;
      tick();
    end
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
